// File: rtl/ni_packetizer_if.sv
// ni_packetizer_if
//   Groups the core-side request handshake and the router-side flit
//   handshake of the network-interface packetizer.
//   Signals:
//     req_valid / req_dest / req_data / req_ready : core -> NI message request
//     noc_ready / flit_out / flit_out_valid       : NI -> router flit stream
//   Modports:
//     master : the environment (core + router), drives requests and noc_ready
//     slave  : the packetizer itself
interface ni_packetizer_if;
  logic        req_valid;
  logic [1:0]  req_dest;
  logic [15:0] req_data;
  logic        req_ready;
  logic        noc_ready;
  logic [7:0]  flit_out;
  logic        flit_out_valid;

  modport master (
    output req_valid, req_dest, req_data, noc_ready,
    input  req_ready, flit_out, flit_out_valid
  );

  modport slave (
    input  req_valid, req_dest, req_data, noc_ready,
    output req_ready, flit_out, flit_out_valid
  );
endinterface

// File: rtl/ni_packetizer.sv
// ni_packetizer
//   Turns a 16-bit message from the local core into a five-flit packet:
//   one head flit {HEAD, dest} followed by four body flits, each carrying
//   one payload nibble (most significant first). Requests addressed to the
//   local node are discarded with a one-cycle pkt_drop pulse.
//   Ports:
//     clk           : clock, all state changes on the rising edge
//     rst           : synchronous active-low reset
//     current_node  : local node ID, sampled only when a request is accepted
//     bus (slave)   : request handshake and flit stream, see ni_packetizer_if
//     pkt_sent      : one-cycle pulse after the last body flit transfers
//     pkt_drop      : one-cycle pulse when a self-addressed request is dropped
//     stall_cnt     : saturating count of stalled flit cycles for the
//                     current (or most recent) packet
//   Every output is a flop; the next-output values are derived from the
//   next-state values so each output lines up with the state it describes.
module ni_packetizer #(
  parameter logic [5:0] HEAD = 6'b101111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] current_node,
  ni_packetizer_if.slave bus,
  output logic       pkt_sent,
  output logic       pkt_drop,
  output logic [7:0] stall_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  // Payload nibble k, most significant nibble first.
  function automatic logic [3:0] body_nibble(input logic [15:0] data, input logic [1:0] k);
    case (k)
      2'd0:    return data[15:12];
      2'd1:    return data[11:8];
      2'd2:    return data[7:4];
      2'd3:    return data[3:0];
      default: return 4'h0;
    endcase
  endfunction

  // Body flits start with 2'b01, so they are never zero (idle) and never
  // match a head marker whose top bits are 2'b10.
  function automatic logic [7:0] body_flit(input logic [15:0] data, input logic [1:0] k);
    return {2'b01, k, body_nibble(data, k)};
  endfunction

  logic [1:0]  state_r,     state_s;
  logic [1:0]  seq_r,       seq_s;
  logic [1:0]  dest_r,      dest_s;
  logic [15:0] data_r,      data_s;
  logic        req_ready_r, req_ready_s;
  logic [7:0]  flit_r,      flit_s;
  logic        flit_vld_r,  flit_vld_s;
  logic        sent_r,      sent_s;
  logic        drop_r,      drop_s;
  logic [7:0]  stall_r,     stall_s;

  // Next-state, capture and stall-count logic.
  always_comb begin
    state_s = state_r;
    seq_s   = seq_r;
    dest_s  = dest_r;
    data_s  = data_r;
    sent_s  = 1'b0;
    drop_s  = 1'b0;

    // Stall counting only happens while a flit is offered and refused.
    if (flit_vld_r && !bus.noc_ready) begin
      if (stall_r != 8'hFF) begin
        stall_s = stall_r + 8'd1;
      end else begin
        stall_s = stall_r;
      end
    end else begin
      stall_s = stall_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          dest_s  = bus.req_dest;
          data_s  = bus.req_data;
          seq_s   = 2'd0;
          stall_s = 8'd0;
          if (bus.req_dest == current_node) begin
            state_s = ST_DROP;
            drop_s  = 1'b1;
          end else begin
            state_s = ST_HEAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HEAD: begin
        if (bus.noc_ready) begin
          state_s = ST_BODY;
          seq_s   = 2'd0;
        end else begin
          state_s = ST_HEAD;
        end
      end
      ST_BODY: begin
        if (bus.noc_ready) begin
          if (seq_r == 2'd3) begin
            state_s = ST_IDLE;
            sent_s  = 1'b1;
          end else begin
            seq_s = seq_r + 2'd1;
          end
        end else begin
          state_s = ST_BODY;
        end
      end
      ST_DROP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the cycle after the edge, derived from the next state.
  always_comb begin
    req_ready_s = 1'b0;
    flit_vld_s  = 1'b0;
    flit_s      = 8'h00;
    case (state_s)
      ST_IDLE: begin
        req_ready_s = 1'b1;
      end
      ST_HEAD: begin
        flit_vld_s = 1'b1;
        flit_s     = {HEAD, dest_s};
      end
      ST_BODY: begin
        flit_vld_s = 1'b1;
        flit_s     = body_flit(data_s, seq_s);
      end
      ST_DROP: begin
        flit_vld_s = 1'b0;
      end
      default: begin
        req_ready_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      seq_r       <= 2'd0;
      dest_r      <= 2'd0;
      data_r      <= 16'h0000;
      req_ready_r <= 1'b1;
      flit_r      <= 8'h00;
      flit_vld_r  <= 1'b0;
      sent_r      <= 1'b0;
      drop_r      <= 1'b0;
      stall_r     <= 8'd0;
    end else begin
      state_r     <= state_s;
      seq_r       <= seq_s;
      dest_r      <= dest_s;
      data_r      <= data_s;
      req_ready_r <= req_ready_s;
      flit_r      <= flit_s;
      flit_vld_r  <= flit_vld_s;
      sent_r      <= sent_s;
      drop_r      <= drop_s;
      stall_r     <= stall_s;
    end
  end

  assign bus.req_ready      = req_ready_r;
  assign bus.flit_out       = flit_r;
  assign bus.flit_out_valid = flit_vld_r;
  assign pkt_sent           = sent_r;
  assign pkt_drop           = drop_r;
  assign stall_cnt          = stall_r;

endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer
//   Self-checking bench for ni_packetizer. A transaction-level model keeps
//   the packet as a queue of expected flits; outputs are compared every
//   cycle on the falling edge. Directed scenarios plus a randomized run.
module tb_ni_packetizer;

  localparam logic [5:0] HEAD_P = 6'b101111;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] current_node;
  logic       pkt_sent;
  logic       pkt_drop;
  logic [7:0] stall_cnt;

  ni_packetizer_if bus();

  ni_packetizer #(.HEAD(HEAD_P)) dut (
    .clk          (clk),
    .rst          (rst),
    .current_node (current_node),
    .bus          (bus.slave),
    .pkt_sent     (pkt_sent),
    .pkt_drop     (pkt_drop),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_flits[$];
  bit m_drop;
  bit m_sent;
  int m_stall;

  // Flits observed transferring to the router
  int seen[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flits.delete();
    m_drop  = 1'b0;
    m_sent  = 1'b0;
    m_stall = 0;
  endtask

  task automatic model_step(input bit rv, input int rd, input int rdat,
                            input bit nr, input int node, input bit rst_v);
    bit o_valid;
    bit o_ready;
    o_valid = (m_flits.size() != 0);
    o_ready = !o_valid && !m_drop;
    if (!rst_v) begin
      model_reset();
    end else begin
      m_sent = 1'b0;
      m_drop = 1'b0;
      if (o_valid) begin
        if (nr) begin
          void'(m_flits.pop_front());
          if (m_flits.size() == 0) m_sent = 1'b1;
        end else if (m_stall < 255) begin
          m_stall++;
        end
      end
      if (o_ready && rv) begin
        m_stall = 0;
        if (rd == node) begin
          m_drop = 1'b1;
        end else begin
          m_flits.push_back(int'(HEAD_P) * 4 + rd);
          for (int k = 0; k < 4; k++)
            m_flits.push_back(64 + k * 16 + ((rdat >> (12 - 4 * k)) & 15));
        end
      end
    end
  endtask

  task automatic compare_outputs();
    bit e_valid;
    e_valid = (m_flits.size() != 0);
    check("flit_out_valid", int'(bus.flit_out_valid), int'(e_valid));
    check("flit_out", int'(bus.flit_out), e_valid ? m_flits[0] : 0);
    check("req_ready", int'(bus.req_ready), int'(!e_valid && !m_drop));
    check("pkt_sent", int'(pkt_sent), int'(m_sent));
    check("pkt_drop", int'(pkt_drop), int'(m_drop));
    check("stall_cnt", int'(stall_cnt), m_stall);
  endtask

  // One clock cycle: drive at the falling edge, step the model on the
  // rising edge, compare at the next falling edge.
  task automatic cycle(input bit rv, input int rd, input int rdat,
                       input bit nr, input int node, input bit rst_v);
    bus.req_valid = rv;
    bus.req_dest  = 2'(rd);
    bus.req_data  = 16'(rdat);
    bus.noc_ready = nr;
    current_node  = 2'(node);
    rst           = rst_v;
    if (rst_v && bus.flit_out_valid && nr) seen.push_back(int'(bus.flit_out));
    @(posedge clk);
    model_step(rv, rd, rdat, nr, node, rst_v);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit nr, input int node);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, nr, node, 1'b1);
  endtask

  task automatic check_seen(input string tag, input int exp[]);
    check({tag, "_count"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      check(tag, seen[i], exp[i]);
  endtask

  initial begin
    int pkt_a5c3[] = '{32'hBE, 32'h4A, 32'h55, 32'h6C, 32'h73};
    int pkt_two[]  = '{32'hBE, 32'h4A, 32'h55, 32'h6C, 32'h73,
                       32'hBE, 32'h4A, 32'h55, 32'h6C, 32'h73};
    int pkt_zero[] = '{32'hBF, 32'h40, 32'h50, 32'h60, 32'h70};
    int stall_pat[] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 1};
    int sent_seen;

    bus.req_valid = 1'b0;
    bus.req_dest  = 2'd0;
    bus.req_data  = 16'h0000;
    bus.noc_ready = 1'b1;
    current_node  = 2'd0;
    rst           = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state
    cycle(1'b0, 0, 0, 1'b1, 0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 0, 1'b0);
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_flit_valid", int'(bus.flit_out_valid), 0);
    check("rst_flit", int'(bus.flit_out), 0);

    // Basic packet, router always ready
    seen.delete();
    cycle(1'b1, 2, 16'hA5C3, 1'b1, 0, 1'b1);
    idle(5, 1'b1, 0);
    check("basic_sent", int'(pkt_sent), 1);
    check("basic_stall", int'(stall_cnt), 0);
    idle(1, 1'b1, 0);
    check("basic_sent_clear", int'(pkt_sent), 0);
    check_seen("basic_flits", pkt_a5c3);

    // Stalls on the head and on body1
    seen.delete();
    cycle(1'b1, 2, 16'hA5C3, 1'b1, 0, 1'b1);
    foreach (stall_pat[i]) cycle(1'b0, 0, 0, stall_pat[i][0], 0, 1'b1);
    check("stall_total", int'(stall_cnt), 5);
    check_seen("stall_flits", pkt_a5c3);
    idle(2, 1'b1, 0);
    check("stall_hold_idle", int'(stall_cnt), 5);

    // Self-addressed request is dropped
    cycle(1'b1, 1, 16'h1234, 1'b1, 1, 1'b1);
    check("drop_pulse", int'(pkt_drop), 1);
    check("drop_no_valid", int'(bus.flit_out_valid), 0);
    idle(1, 1'b1, 1);
    check("drop_ready_back", int'(bus.req_ready), 1);
    check("drop_pulse_end", int'(pkt_drop), 0);

    // Back-to-back packets with req_valid held high
    seen.delete();
    for (int i = 0; i < 12; i++) cycle(1'b1, 2, 16'hA5C3, 1'b1, 0, 1'b1);
    idle(2, 1'b1, 0);
    check_seen("b2b_flits", pkt_two);

    // Reset while body1 is stalled; a reset pulse between edges is ignored
    cycle(1'b1, 3, 16'hBEEF, 1'b1, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    rst = 1'b0;
    #2;
    compare_outputs();
    check("glitch_valid", int'(bus.flit_out_valid), 1);
    rst = 1'b1;
    cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
    check("midrst_valid", int'(bus.flit_out_valid), 0);
    check("midrst_ready", int'(bus.req_ready), 1);
    check("midrst_stall", int'(stall_cnt), 0);
    sent_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 0, 0, 1'b1, 0, 1'b1);
      if (pkt_sent) sent_seen++;
    end
    check("midrst_no_sent", sent_seen, 0);

    // All-zero payload still yields nonzero body flits
    seen.delete();
    cycle(1'b1, 3, 16'h0000, 1'b1, 0, 1'b1);
    idle(6, 1'b1, 0);
    check_seen("zero_flits", pkt_zero);

    // Stall counter saturation
    cycle(1'b1, 1, 16'h0F0F, 1'b1, 2, 1'b1);
    idle(300, 1'b0, 2);
    check("stall_saturate", int'(stall_cnt), 255);
    idle(6, 1'b1, 2);

    // Randomized traffic, node ID wandering, occasional reset
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 65535)), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 3)), ($urandom_range(0, 199) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ni_packetizer.md
NI_PACKETIZER -- requirements
Module: ni_packetizer

Interface
REQ-001 Parameter HEAD, default 6'b101111, head-flit marker in flit[7:2].
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 current_node  input  2  ID of the local node.
REQ-005 req_valid  input  1  core has a message to send.
REQ-006 req_dest  input  2  destination node of the message.
REQ-007 req_data  input  16  message payload.
REQ-008 req_ready  output  1  block can accept a message.
REQ-009 noc_ready  input  1  router accepts a flit from the NI this cycle.
REQ-010 flit_out  output  8  flit presented to the router.
REQ-011 flit_out_valid  output  1  flit_out holds a valid flit.
REQ-012 pkt_sent  output  1  one-cycle pulse when a packet's last flit transfers.
REQ-013 pkt_drop  output  1  one-cycle pulse when a self-addressed request is discarded.
REQ-014 stall_cnt  output  8  stall cycles for the current or last packet.

Function
REQ-015 The block SHALL register all outputs; none are combinational from inputs.
REQ-016 The FSM SHALL have the states IDLE, HEAD, BODY and DROP.
REQ-017 In IDLE: req_ready=1; flit_out_valid=0; flit_out=8'h00.
REQ-018 On req_valid&&req_ready, the block SHALL:
  - capture req_dest and req_data;
  - clear stall_cnt and the body-sequence counter;
  - go to DROP if req_dest==current_node, else go to HEAD.
REQ-019 DROP SHALL last one cycle: pkt_drop=1, nothing injected, then IDLE.
REQ-020 In HEAD: flit_out={HEAD, dest}, flit_out_valid=1.
REQ-021 In BODY with seq k (0..3): flit_out={2'b01, k[1:0], nibble k}, flit_out_valid=1.
  - nibble 0=data[15:12], 1=data[11:8], 2=data[7:4], 3=data[3:0].
REQ-022 Body flits SHALL be nonzero and never carry HEAD in [7:2], so the router cannot see them as idle or head.
REQ-023 A flit SHALL transfer only on a cycle with flit_out_valid&&noc_ready.
  - Without transfer, flit_out and flit_out_valid SHALL stay stable.
REQ-024 On a HEAD transfer, go to BODY with seq=0.
  - On a BODY transfer with seq<3, increment seq.
  - On a BODY transfer with seq==3, go to IDLE and assert pkt_sent for the next cycle.
REQ-025 Each cycle with flit_out_valid&&!noc_ready SHALL increment stall_cnt, saturating at 8'hFF.
  - stall_cnt holds its value in IDLE until the next accept.
REQ-026 Latency with noc_ready held at 1 and accept at edge N:
  - head valid in cycle N+1; body0..body3 in cycles N+2..N+5;
  - pkt_sent=1 and req_ready=1 in cycle N+6.
REQ-027 req_ready SHALL be 0 in HEAD, BODY and DROP; requests there are ignored.
REQ-028 A new request SHALL be accepted on the same cycle pkt_sent is high (back-to-back packets, one idle cycle between).
REQ-029 Changes to current_node SHALL only affect the drop decision at accept time.

Reset
REQ-030 While rst==0 at a clock edge, the block SHALL go to IDLE and set:
  - req_ready=1, flit_out=8'h00, flit_out_valid=0;
  - pkt_sent=0, pkt_drop=0, stall_cnt=0;
  - seq=0, captured dest/data=0.
REQ-031 Reset mid-packet SHALL abort the packet with no further flits and no pkt_sent pulse.
REQ-032 Reset SHALL take effect only on a clock edge; asserting rst between edges SHALL not change outputs.

Verification
REQ-033 current_node=0; req dest=2, data=16'hA5C3; noc_ready=1
  -> flits 0xBE,0x4A,0x55,0x6C,0x73 on consecutive cycles; then pkt_sent=1 for 1 cycle; stall_cnt=0.
REQ-034 As REQ-033, but noc_ready=0 for 3 cycles during the head and 2 cycles during body1
  -> each flit held stable while stalled; stall_cnt=5; flit order unchanged.
REQ-035 current_node=1; req dest=1
  -> pkt_drop=1 for 1 cycle; flit_out_valid stays 0; req_ready returns to 1 the next cycle.
REQ-036 Two requests with req_valid held high, noc_ready=1
  -> second head appears 2 cycles after the first packet's last flit; req_valid ignored while busy.
REQ-037 rst=0 for one edge while body1 is stalled
  -> next cycle flit_out_valid=0, req_ready=1, stall_cnt=0, no pkt_sent.
REQ-038 data=16'h0000, dest=3, node=0
  -> body flits 0x40,0x50,0x60,0x70, all nonzero.
